// File: rtl/adder48_pkg.sv
// adder48_pkg
// Shared definitions for the sequential 48-bit adder: slice geometry
// constants and the slice-sequencing FSM state encoding.
package adder48_pkg;

  localparam int SLICE_W  = 16;
  localparam int N_SLICES = 3;
  localparam int DATA_W   = SLICE_W * N_SLICES;

  // IDLE waits for operands, SLk computes slice k, DONE holds the result.
  typedef enum logic [2:0] {
    IDLE,
    SL0,
    SL1,
    SL2,
    DONE
  } state_t;

endpackage

// File: rtl/adder16.sv
// adder16
// Combinational 16-bit ripple slice with carry-in and carry-out.
// Ports:
//   a, b  : 16-bit operands
//   ci    : carry-in
//   s     : 16-bit sum
//   co    : carry-out
module adder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);

  // A 17-bit add keeps the carry-out in the top bit.
  assign {co, s} = {1'b0, a} + {1'b0, b} + {16'b0, ci};

endmodule

// File: rtl/adder48_seq.sv
// adder48_seq
// Area-reduced 48-bit adder. One adder16 slice is reused over three
// cycles, with the carry rippling through a register between slices.
// Operands arrive on a valid/ready handshake and results leave on another.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (A, B, c0)
//   A, B, c0             : 48-bit operands and carry-in
//   out_valid/out_ready  : result handshake (S, c48[, ovf])
//   S, c48               : 48-bit sum and carry-out
//   ovf                  : signed overflow, only with ADDER48_SEQ_OVF_EN
// Configuration macro: ADDER48_SEQ_OVF_EN adds the ovf port and its flop.
module adder48_seq
  import adder48_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DATA_W:1] A,
  input  logic [DATA_W:1] B,
  input  logic            c0,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DATA_W:1] S,
  output logic            c48
`ifdef ADDER48_SEQ_OVF_EN
  ,
  output logic            ovf
`endif
);

  state_t              state;
  logic [DATA_W:1]     a_reg;
  logic [DATA_W:1]     b_reg;
  logic                carry;
  logic [SLICE_W-1:0]  slice_a;
  logic [SLICE_W-1:0]  slice_b;
  logic [SLICE_W-1:0]  slice_sum;
  logic                slice_co;
  logic                accept;

  // A new operand set may be taken in the same cycle the held result
  // is consumed, so in_ready looks through to out_ready in DONE.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // Operand slice multiplexer: the state selects which 16-bit slice
  // of the operand registers feeds the shared adder.
  always_comb begin
    slice_a = a_reg[SLICE_W:1];
    slice_b = b_reg[SLICE_W:1];
    case (state)
      SL1: begin
        slice_a = a_reg[2*SLICE_W:SLICE_W+1];
        slice_b = b_reg[2*SLICE_W:SLICE_W+1];
      end
      SL2: begin
        slice_a = a_reg[DATA_W:2*SLICE_W+1];
        slice_b = b_reg[DATA_W:2*SLICE_W+1];
      end
      default: begin
        slice_a = a_reg[SLICE_W:1];
        slice_b = b_reg[SLICE_W:1];
      end
    endcase
  end

  adder16 u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry),
    .s  (slice_sum),
    .co (slice_co)
  );

  // Sequencing FSM with operand, carry and result registers.
  // S keeps its old contents until each slice overwrites its part, so a
  // stalled result stays stable for as long as DONE is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      S     <= '0;
      c48   <= 1'b0;
`ifdef ADDER48_SEQ_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= A;
            b_reg <= B;
            carry <= c0;
            state <= SL0;
          end
        end
        SL0: begin
          S[SLICE_W:1] <= slice_sum;
          carry        <= slice_co;
          state        <= SL1;
        end
        SL1: begin
          S[2*SLICE_W:SLICE_W+1] <= slice_sum;
          carry                  <= slice_co;
          state                  <= SL2;
        end
        SL2: begin
          S[DATA_W:2*SLICE_W+1] <= slice_sum;
          c48                   <= slice_co;
`ifdef ADDER48_SEQ_OVF_EN
          // Like-signed operands whose sum sign differs have overflowed.
          ovf <= (a_reg[DATA_W] == b_reg[DATA_W]) &&
                 (slice_sum[SLICE_W-1] != a_reg[DATA_W]);
`endif
          state <= DONE;
        end
        DONE: begin
          if (accept) begin
            a_reg <= A;
            b_reg <= B;
            carry <= c0;
            state <= SL0;
          end else if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder48_seq.sv
// tb_adder48_seq
// Self-checking bench for adder48_seq. Expected results are computed from
// the operands when they are accepted and queued; a monitor pops and
// compares them when the DUT presents a result that is consumed.
// Define ADDER48_SEQ_OVF_EN to also check the ovf output.
module tb_adder48_seq;

  typedef struct {
    logic [48:1] s;
    logic        c48;
    logic        ovf;
    int          acc_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [48:1] A = '0;
  logic [48:1] B = '0;
  logic        c0 = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [48:1] S;
  logic        c48;
`ifdef ADDER48_SEQ_OVF_EN
  logic        ovf;
`endif

  exp_t sb[$];
  int   total = 0;
  int   passes = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;

  adder48_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .c0        (c0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .c48       (c48)
`ifdef ADDER48_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // 10 ns clock; inputs change just after rising edges, outputs are
  // sampled on falling edges.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    total++;
    if (got !== exp)
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      passes++;
  endtask

  function automatic logic [48:1] rand48();
    logic [31:0] hi;
    logic [31:0] lo;
    hi = $urandom();
    lo = $urandom();
    return {hi[15:0], lo};
  endfunction

  // Reference model: unsigned add with carry-out plus signed overflow.
  function automatic exp_t model(input logic [48:1] a, input logic [48:1] b,
                                 input logic ci, input int acc);
    exp_t e;
    logic [49:1] full;
    full = {1'b0, a} + {1'b0, b} + {48'b0, ci};
    e.s       = full[48:1];
    e.c48     = full[49];
    e.ovf     = (a[48] == b[48]) && (full[48] != a[48]);
    e.acc_cyc = acc;
    return e;
  endfunction

  // Drives one operand set (called just after a rising edge), waits for
  // in_ready, and queues the expected result at the accept edge. Garbage
  // is left on the operand pins afterwards, which the DUT must ignore.
  task automatic applyStimulus(input logic [48:1] a, input logic [48:1] b,
                               input logic ci, output int waited);
    logic ok;
    ok = 1'b0;
    waited = 0;
    A = a;
    B = b;
    c0 = ci;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      waited++;
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checkOutput("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      sb.push_back(model(a, b, ci, cyc));
      in_valid = 1'b0;
      A = rand48();
      B = rand48();
      c0 = 1'b1;
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Result monitor: checks latency when out_valid rises and compares the
  // result against the queue head whenever it is consumed.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) checkOutput("unexpected_valid", 64'd1, 64'd0);
        else checkOutput("latency", 64'(cyc - sb[0].acc_cyc), 64'd3);
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("sum", 64'(S), 64'(e.s));
        checkOutput("c48", 64'(c48), 64'(e.c48));
`ifdef ADDER48_SEQ_OVF_EN
        checkOutput("ovf", 64'(ovf), 64'(e.ovf));
`endif
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    int   w;
    exp_t held;
    logic seen;

    #2;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_S", 64'(S), 64'd0);
    checkOutput("rst_c48", 64'(c48), 64'd0);
`ifdef ADDER48_SEQ_OVF_EN
    checkOutput("rst_ovf", 64'(ovf), 64'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases, including carry ripple across slice boundaries
    // and the signed overflow corners.
    applyStimulus(48'h0000_0000_0001, 48'h0000_0000_0002, 1'b0, w);
    applyStimulus(48'hFFFF_FFFF_FFFF, 48'h0000_0000_0000, 1'b1, w);
    applyStimulus(48'h0000_FFFF_FFFF, 48'h0000_0000_0001, 1'b0, w);
    applyStimulus(48'h7FFF_FFFF_FFFF, 48'h0000_0000_0001, 1'b0, w);
    applyStimulus(48'h8000_0000_0000, 48'h8000_0000_0000, 1'b0, w);
    applyStimulus(48'h0000_0000_FFFF, 48'h0000_0000_0000, 1'b1, w);
    for (int i = 0; i < 8; i++)
      applyStimulus(rand48(), rand48(), 1'($urandom_range(0, 1)), w);
    waitDrain();

    // Stall: hold the result for 10 cycles with out_ready low.
    out_ready = 1'b0;
    applyStimulus(48'h1234_5678_9ABC, 48'hFEDC_BA98_7654, 1'b1, w);
    held = model(48'h1234_5678_9ABC, 48'hFEDC_BA98_7654, 1'b1, 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("stall_valid_seen", 64'(seen), 64'd1);
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall_S", 64'(S), 64'(held.s));
      checkOutput("stall_c48", 64'(c48), 64'(held.c48));
      checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
      checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    // Release together with a new operand set: accept in the same cycle.
    out_ready = 1'b1;
    applyStimulus(48'h0000_0001_0000, 48'h0000_0000_FFFF, 1'b1, w);
    checkOutput("same_cycle_accept_wait", 64'(w), 64'd1);
    waitDrain();

    // Reset while in SL1 aborts the add immediately.
    applyStimulus(48'h0000_0000_FFFF, 48'h0000_0000_0001, 1'b0, w);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_S", 64'(S), 64'd0);
    checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
    checkOutput("abort_c48", 64'(c48), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(48'd5, 48'd7, 1'b0, w);
    waitDrain();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
